// File: rtl/sseg_scan_driver_pkg.sv
`default_nettype none
//============================================================================
// Module : sseg_pkg
// Brief  : Glyph codes, segment constants and the 5-bit glyph decoder
//          shared by the 7-segment display blocks.
// Rev    : 1.0  initial release
//============================================================================
package sseg_pkg;

    localparam logic [4:0] GLY_U     = 5'h10;
    localparam logic [4:0] GLY_DASH  = 5'h11;
    localparam logic [4:0] GLY_BLANK = 5'h12;
    localparam logic [4:0] GLY_N     = 5'h13;
    localparam logic [4:0] GLY_LO_O  = 5'h14;
    localparam logic [4:0] GLY_UP_O  = 5'h15;
    localparam logic [4:0] GLY_L     = 5'h16;
    localparam logic [4:0] GLY_LL    = 5'h17;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Per-slot snapshot of one digit's attributes.
    typedef struct packed {
        logic [4:0] code;
        logic       dp;
        logic       en;
        logic       blink;
    } slot_latch_t;

    // Segments a..g in bits [6:0], active low.
    function automatic logic [6:0] seg_decode(input logic [4:0] code);
        logic [6:0] seg;
        case (code)
            5'h00:     seg = 7'b0000001;
            5'h01:     seg = 7'b1001111;
            5'h02:     seg = 7'b0010010;
            5'h03:     seg = 7'b0000110;
            5'h04:     seg = 7'b1001100;
            5'h05:     seg = 7'b0100100;
            5'h06:     seg = 7'b0100000;
            5'h07:     seg = 7'b0001111;
            5'h08:     seg = 7'b0000000;
            5'h09:     seg = 7'b0000100;
            5'h0A:     seg = 7'b0001000;
            5'h0B:     seg = 7'b1100000;
            5'h0C:     seg = 7'b0110001;
            5'h0D:     seg = 7'b1000010;
            5'h0E:     seg = 7'b0110000;
            5'h0F:     seg = 7'b0111000;
            GLY_U:     seg = 7'b1000001;
            GLY_DASH:  seg = 7'b1111110;
            GLY_BLANK: seg = 7'b1111111;
            GLY_N:     seg = 7'b0001001;
            GLY_LO_O:  seg = 7'b1100010;
            GLY_UP_O:  seg = 7'b0011100;
            GLY_L:     seg = 7'b1111001;
            GLY_LL:    seg = 7'b1001001;
            default:   seg = 7'b1111100;
        endcase
        return seg;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sseg_scan_driver_if.sv
`default_nettype none
//============================================================================
// Module : sseg_scan_driver_if
// Brief  : Display data in / pin drive out bundle for the scan driver.
// Rev    : 1.0  initial release
//============================================================================
interface sseg_scan_driver_if #(
    parameter int NUM_DIGITS = 3
);
    logic [5*NUM_DIGITS-1:0] digits_in;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic [NUM_DIGITS-1:0]   en_in;
    logic [NUM_DIGITS-1:0]   blink_in;
    logic [3:0]              bright_in;
    logic [NUM_DIGITS-1:0]   an_out;
    logic [7:0]              sseg_out;

    // master: display-formatting logic; slave: the scan driver.
    modport master (
        output digits_in, dp_in, en_in, blink_in, bright_in,
        input  an_out, sseg_out
    );

    modport slave (
        input  digits_in, dp_in, en_in, blink_in, bright_in,
        output an_out, sseg_out
    );
endinterface
`default_nettype wire

// File: rtl/sseg_scan_driver_glyph_decode.sv
`default_nettype none
//============================================================================
// Module : sseg_glyph_decode
// Brief  : Combinational 5-bit glyph code to active-low a..g segments.
// Rev    : 1.0  initial release
//============================================================================
module sseg_glyph_decode
    import sseg_pkg::*;
(
    input  wire logic [4:0] i_code,
    output logic      [6:0] o_seg
);
    assign o_seg = seg_decode(i_code);
endmodule
`default_nettype wire

// File: rtl/sseg_scan_driver.sv
`default_nettype none
//============================================================================
// Module : sseg_scan_driver
// Brief  : Time-multiplexed common-anode 7-segment driver with dead time,
//          PWM brightness and per-digit blink.
// Rev    : 1.0  initial release
//============================================================================
module sseg_scan_driver
    import sseg_pkg::*;
#(
    parameter int NUM_DIGITS = 3,
    parameter int DIV_BITS   = 16,
    parameter int DEAD_CYC   = 64,
    parameter int BLINK_BITS = 24
) (
    input  wire logic         clk,
    input  wire logic         reset,
    sseg_scan_driver_if.slave disp
);
    localparam int                  c_IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [DIV_BITS-1:0] c_DEAD   = DIV_BITS'(DEAD_CYC);
    localparam logic [DIV_BITS-1:0] c_SLOT_MAX = '1;
    localparam logic [c_IDX_W-1:0]  c_IDX_LAST = c_IDX_W'(NUM_DIGITS - 1);

    logic [DIV_BITS-1:0]   r_slot_cnt;
    logic [c_IDX_W-1:0]    r_idx;
    logic [BLINK_BITS-1:0] r_blink_cnt;
    slot_latch_t           r_lat;

    slot_latch_t           w_live;
    slot_latch_t           w_cur;
    logic                  w_slot_start;
    logic                  w_on;
    logic [6:0]            w_seg;
    logic [NUM_DIGITS-1:0] w_an;

    assign w_slot_start = (r_slot_cnt == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_slot_cnt  <= '0;
            r_idx       <= '0;
            r_blink_cnt <= '0;
        end else begin
            r_slot_cnt  <= r_slot_cnt + 1'b1;
            r_blink_cnt <= r_blink_cnt + 1'b1;
            if (r_slot_cnt == c_SLOT_MAX)
                r_idx <= (r_idx == c_IDX_LAST) ? '0 : r_idx + 1'b1;
        end
    end

    always_comb begin
        w_live = '{code: disp.digits_in[4:0], dp: disp.dp_in[0],
                   en: disp.en_in[0], blink: disp.blink_in[0]};
        for (int i = 1; i < NUM_DIGITS; i++) begin
            if (r_idx == c_IDX_W'(i))
                w_live = '{code: disp.digits_in[5*i +: 5], dp: disp.dp_in[i],
                           en: disp.en_in[i], blink: disp.blink_in[i]};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_lat <= '0;
        else if (w_slot_start)
            r_lat <= w_live;
    end

    // The capture cycle itself already drives from the incoming values so
    // the output path never sees the previous digit's snapshot.
    assign w_cur = w_slot_start ? w_live : r_lat;

    assign w_on = (r_slot_cnt >= c_DEAD)
               && ((disp.bright_in == 4'hF) || (r_slot_cnt[DIV_BITS-1 -: 4] < disp.bright_in))
               && !(w_cur.blink && r_blink_cnt[BLINK_BITS-1]);

    sseg_glyph_decode u_decode (
        .i_code (w_cur.code),
        .o_seg  (w_seg)
    );

    always_comb begin
        w_an = '1;
        for (int i = 0; i < NUM_DIGITS; i++)
            w_an[i] = ~(w_on && (r_idx == c_IDX_W'(i)));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            disp.an_out   <= '1;
            disp.sseg_out <= 8'hFF;
        end else begin
            disp.an_out   <= w_an;
            disp.sseg_out <= w_on ? {~w_cur.dp, (w_cur.en ? w_seg : SEG_OFF)} : 8'hFF;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sseg_scan_driver.sv
`default_nettype none
//============================================================================
// Module : tb_sseg_scan_driver
// Brief  : Self-checking bench for sseg_scan_driver against a cycle-time model.
// Rev    : 1.0  initial release
//============================================================================
module tb_sseg_scan_driver;
    localparam int ND    = 3;
    localparam int DB    = 6;
    localparam int DEAD  = 2;
    localparam int BB    = 10;
    localparam int SLOT  = 1 << DB;
    localparam int FRAME = SLOT * ND;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    sseg_scan_driver_if #(.NUM_DIGITS(ND)) disp ();

    sseg_scan_driver #(
        .NUM_DIGITS (ND),
        .DIV_BITS   (DB),
        .DEAD_CYC   (DEAD),
        .BLINK_BITS (BB)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .disp  (disp)
    );

    always #5 clk = ~clk;

    logic [6:0] c_glyph [0:31] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000,
        7'b1000001, 7'b1111110, 7'b1111111, 7'b0001001,
        7'b1100010, 7'b0011100, 7'b1111001, 7'b1001001,
        7'b1111100, 7'b1111100, 7'b1111100, 7'b1111100,
        7'b1111100, 7'b1111100, 7'b1111100, 7'b1111100
    };

    int checks   = 0;
    int failures = 0;
    int t        = 0;
    int lit_cnt  = 0;

    // Snapshot of the digit being shown, taken at each slot start.
    int m_code  = 0;
    bit m_dp    = 1'b0;
    bit m_en    = 1'b0;
    bit m_blink = 1'b0;

    task automatic check_out(input string tag, input logic [2:0] exp_an, input logic [7:0] exp_sseg);
        checks++;
        assert (disp.an_out === exp_an) else begin
            failures++;
            $error("FAIL %s an_out t=%0d got %b expected %b", tag, t, disp.an_out, exp_an);
        end
        checks++;
        assert (disp.sseg_out === exp_sseg) else begin
            failures++;
            $error("FAIL %s sseg_out t=%0d got %h expected %h", tag, t, disp.sseg_out, exp_sseg);
        end
    endtask

    // One clock: predict from the cycle number t, then compare after the edge.
    task automatic step();
        int         s, id;
        bit         on;
        logic [2:0] exp_an;
        logic [7:0] exp_sseg;
        s  = t % SLOT;
        id = (t / SLOT) % ND;
        if (s == 0) begin
            m_code  = int'(disp.digits_in[id*5 +: 5]);
            m_dp    = disp.dp_in[id];
            m_en    = disp.en_in[id];
            m_blink = disp.blink_in[id];
        end
        on = (s >= DEAD)
          && (disp.bright_in == 4'd15 || (s / (SLOT / 16)) < int'(disp.bright_in))
          && !(m_blink && ((t / (1 << (BB - 1))) % 2 == 1));
        exp_an   = on ? ~(3'b001 << id) : 3'b111;
        exp_sseg = on ? {~m_dp, (m_en ? c_glyph[m_code] : 7'h7F)} : 8'hFF;
        @(posedge clk);
        #1;
        check_out("model", exp_an, exp_sseg);
        if (disp.an_out !== 3'b111) lit_cnt++;
        t++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic run_to_phase(input int ph);
        do step(); while (t % FRAME != ph);
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        t     = 0;
    endtask

    initial begin
        disp.digits_in = {5'h02, 5'h01, 5'h0A};
        disp.en_in     = 3'b111;
        disp.dp_in     = 3'b010;
        disp.blink_in  = 3'b000;
        disp.bright_in = 4'd15;

        // Reset held, then released; first anode at cycle DEAD+1.
        repeat (3) @(posedge clk);
        #1;
        check_out("reset_hold", 3'b111, 8'hFF);
        release_reset();
        run(DEAD);
        check_out("dead_time", 3'b111, 8'hFF);
        step();
        check_out("first_lit", 3'b110, 8'h88);

        // Glyph decode and dp for all three digits over two frames.
        run_to_phase(10);
        check_out("digit0", 3'b110, 8'h88);
        run_to_phase(SLOT + 10);
        check_out("digit1", 3'b101, 8'h4F);
        run_to_phase(2 * SLOT + 10);
        check_out("digit2", 3'b011, 8'h92);
        run_to_phase(0);

        // PWM: 14 lit cycles per slot at bright 4, none at bright 0.
        disp.bright_in = 4'd4;
        lit_cnt = 0;
        run(FRAME);
        checks++;
        assert (lit_cnt == 14 * ND) else begin
            failures++;
            $error("FAIL pwm4_lit got %0d expected %0d", lit_cnt, 14 * ND);
        end
        disp.bright_in = 4'd0;
        lit_cnt = 0;
        run(FRAME);
        checks++;
        assert (lit_cnt == 0) else begin
            failures++;
            $error("FAIL pwm0_lit got %0d expected 0", lit_cnt);
        end

        // Blink on digit 2 across two full blink periods.
        disp.bright_in = 4'd15;
        disp.blink_in  = 3'b100;
        run(2 << BB);
        disp.blink_in  = 3'b000;

        // Mid-slot glyph change is held off until the next digit-0 slot.
        disp.dp_in = 3'b000;
        run_to_phase(0);
        run_to_phase(20);
        disp.digits_in[4:0] = 5'h11;
        disp.en_in = 3'b101;
        run_to_phase(40);
        check_out("no_tear", 3'b110, 8'h88);
        run_to_phase(SLOT + 30);
        check_out("en_off", 3'b101, 8'hFF);
        run_to_phase(20);
        check_out("new_glyph", 3'b110, 8'hFE);
        disp.en_in = 3'b111;

        // Asynchronous reset mid-slot of digit 1, then restart at digit 0.
        run_to_phase(SLOT + 20);
        reset = 1'b1;
        #1;
        check_out("async_reset", 3'b111, 8'hFF);
        release_reset();
        run(DEAD + 1);
        check_out("restart", 3'b110, 8'hFE);
        run(FRAME);

        // Randomized inputs at random points in the scan.
        for (int k = 0; k < 24; k++) begin
            disp.digits_in = 15'($urandom);
            disp.dp_in     = 3'($urandom);
            disp.en_in     = 3'($urandom);
            disp.blink_in  = 3'($urandom);
            disp.bright_in = 4'($urandom_range(0, 15));
            run($urandom_range(20, 400));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
